// File: rtl/screen_pkg.sv
// Shared types for the screen sequencer: phase and command codes, pixel width
// and the PAUSE-screen dimming helper.
package screen_pkg;

    localparam int RGB_W = 12;

    typedef enum logic [1:0] {
        PH_MENU  = 2'b00,
        PH_PLAY  = 2'b01,
        PH_PAUSE = 2'b10,
        PH_OVER  = 2'b11
    } phase_t;

    // Numeric order doubles as priority: OVER > BACK > SELECT > NONE.
    typedef enum logic [1:0] {
        CMD_NONE   = 2'b00,
        CMD_SELECT = 2'b01,
        CMD_BACK   = 2'b10,
        CMD_OVER   = 2'b11
    } cmd_t;

    function automatic logic [RGB_W-1:0] dim(input logic [RGB_W-1:0] px);
        return {1'b0, px[11:9], 1'b0, px[7:5], 1'b0, px[3:1]};
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of raster, button, renderer-handshake and pixel signals around the
// screen sequencer; master is the sequencer, slave is its environment.
interface screen_sequencer_if;

    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        btn_select_in;
    logic        btn_back_in;
    logic        game_over_in;
    logic        menu_busy_in;
    logic        menu_finished_in;
    logic [11:0] menu_pixel_in;
    logic [11:0] game_pixel_in;
    logic [1:0]  state_out;
    logic        menu_start_out;
    logic        game_run_out;
    logic        demo_out;
    logic        frame_out;
    logic [11:0] pixel_out;

    modport master (
        input  hcount_in, vcount_in, btn_select_in, btn_back_in, game_over_in,
               menu_busy_in, menu_finished_in, menu_pixel_in, game_pixel_in,
        output state_out, menu_start_out, game_run_out, demo_out, frame_out,
               pixel_out
    );

    modport slave (
        output hcount_in, vcount_in, btn_select_in, btn_back_in, game_over_in,
               menu_busy_in, menu_finished_in, menu_pixel_in, game_pixel_in,
        input  state_out, menu_start_out, game_run_out, demo_out, frame_out,
               pixel_out
    );

endinterface

// File: rtl/screen_pixel_stage.sv
// Final registered pixel mux: menu, game, or (in PAUSE) menu overlay on a
// dimmed game picture.
module screen_pixel_stage
    import screen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  phase_t           phase,
    input  logic [RGB_W-1:0] menu_pixel,
    input  logic [RGB_W-1:0] game_pixel,
    output logic [RGB_W-1:0] pixel
);

    logic [RGB_W-1:0] pixel_d;
    logic [RGB_W-1:0] pixel_q;

    always_comb begin
        pixel_d = menu_pixel;
        case (phase)
            PH_PLAY:  pixel_d = game_pixel;
            PH_PAUSE: pixel_d = (menu_pixel != '0) ? menu_pixel : dim(game_pixel);
            default:  pixel_d = menu_pixel;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pixel_q <= '0;
        else      pixel_q <= pixel_d;
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/screen_sequencer.sv
// MENU/PLAY/PAUSE/OVER phase controller with frame-aligned transitions.
// Define ATTRACT_MODE_EN to enable the idle attract demo.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int H_LAST      = 1279,
    parameter int V_LAST      = 719,
    parameter int OVER_FRAMES = 180
`ifdef ATTRACT_MODE_EN
    ,
    parameter int IDLE_FRAMES = 600
`endif
) (
    input  logic               clk,
    input  logic               rst,
    screen_sequencer_if.master bus
);

    logic       frame_tick;
    cmd_t       new_cmd;
    phase_t     phase_d, phase_q;
    cmd_t       cmd_d, cmd_q;
    logic [9:0] frame_cnt_d, frame_cnt_q, cnt_inc;
    logic       ready_d, ready_q;
    logic       start_d, start_q;
    logic       frame_q, run_q;
`ifdef ATTRACT_MODE_EN
    logic       demo_d, demo_q;
`endif

    always_comb begin
        frame_tick = (bus.hcount_in == 11'(H_LAST)) && (bus.vcount_in == 10'(V_LAST));
        new_cmd = CMD_NONE;
        if (bus.btn_select_in) new_cmd = CMD_SELECT;
        if (bus.btn_back_in)   new_cmd = CMD_BACK;
        if (bus.game_over_in)  new_cmd = CMD_OVER;
        phase_d     = phase_q;
        cmd_d       = (new_cmd > cmd_q) ? new_cmd : cmd_q;
        cnt_inc     = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 10'd1;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
`ifdef ATTRACT_MODE_EN
        demo_d      = demo_q;
`endif
        // A pulse landing on the tick itself is kept for the following frame.
        if (frame_tick) begin
            cmd_d   = new_cmd;
            start_d = (phase_q != PH_PLAY) && !bus.menu_busy_in && !ready_q;
            case (phase_q)
                PH_MENU: begin
                    if (cmd_q == CMD_SELECT && ready_q) phase_d = PH_PLAY;
`ifdef ATTRACT_MODE_EN
                    else if (ready_q && cmd_q == CMD_NONE) begin
                        if (frame_cnt_q == 10'(IDLE_FRAMES - 1)) begin
                            phase_d = PH_PLAY;
                            demo_d  = 1'b1;
                        end else begin
                            frame_cnt_d = cnt_inc;
                        end
                    end else begin
                        frame_cnt_d = '0;
                    end
`endif
                end
                PH_PLAY: begin
                    if (cmd_q == CMD_OVER)      phase_d = PH_OVER;
                    else if (cmd_q == CMD_BACK) phase_d = PH_PAUSE;
`ifdef ATTRACT_MODE_EN
                    if (demo_q && cmd_q != CMD_NONE) phase_d = PH_MENU;
`endif
                end
                PH_PAUSE: begin
                    case (cmd_q)
                        CMD_SELECT: phase_d = PH_PLAY;
                        CMD_BACK:   phase_d = PH_MENU;
                        CMD_OVER:   phase_d = PH_OVER;
                        default:    phase_d = PH_PAUSE;
                    endcase
                end
                default: begin
                    if (cmd_q == CMD_SELECT || frame_cnt_q == 10'(OVER_FRAMES - 1))
                        phase_d = PH_MENU;
                    else
                        frame_cnt_d = cnt_inc;
                end
            endcase
        end
        ready_d = bus.menu_finished_in ? 1'b1 : ready_q;
        if (phase_d != phase_q) begin
            ready_d     = 1'b0;
            frame_cnt_d = '0;
        end
`ifdef ATTRACT_MODE_EN
        if (phase_d != PH_PLAY) demo_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= PH_MENU;
            cmd_q       <= CMD_NONE;
            frame_cnt_q <= '0;
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            frame_q     <= 1'b0;
            run_q       <= 1'b0;
`ifdef ATTRACT_MODE_EN
            demo_q      <= 1'b0;
`endif
        end else begin
            phase_q     <= phase_d;
            cmd_q       <= cmd_d;
            frame_cnt_q <= frame_cnt_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            frame_q     <= frame_tick;
            run_q       <= (phase_d == PH_PLAY);
`ifdef ATTRACT_MODE_EN
            demo_q      <= demo_d;
`endif
        end
    end

    assign bus.state_out      = phase_q;
    assign bus.menu_start_out = start_q;
    assign bus.game_run_out   = run_q;
    assign bus.frame_out      = frame_q;
`ifdef ATTRACT_MODE_EN
    assign bus.demo_out       = demo_q;
`else
    assign bus.demo_out       = 1'b0;
`endif

    screen_pixel_stage u_pixel_stage (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase_q),
        .menu_pixel (bus.menu_pixel_in),
        .game_pixel (bus.game_pixel_in),
        .pixel      (bus.pixel_out)
    );

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: frames are emulated by driving the
// raster counters straight to the last active pixel for one cycle.
module tb_screen_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    screen_sequencer_if sif ();

    screen_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One clock cycle; tick selects the frame-boundary raster position.
    task automatic applyStimulus(input bit tick, input bit sel, input bit back,
                                 input bit over, input bit fin);
        sif.hcount_in        = tick ? 11'd1279 : 11'd100;
        sif.vcount_in        = tick ? 10'd719  : 10'd5;
        sif.btn_select_in    = sel;
        sif.btn_back_in      = back;
        sif.game_over_in     = over;
        sif.menu_finished_in = fin;
        @(posedge clk);
        #1;
        sif.hcount_in        = 11'd100;
        sif.vcount_in        = 10'd5;
        sif.btn_select_in    = 1'b0;
        sif.btn_back_in      = 1'b0;
        sif.game_over_in     = 1'b0;
        sif.menu_finished_in = 1'b0;
    endtask

    initial begin
        tests                = 0;
        failures             = 0;
        rst                  = 1'b0;
        sif.hcount_in        = 11'd0;
        sif.vcount_in        = 10'd0;
        sif.btn_select_in    = 1'b0;
        sif.btn_back_in      = 1'b0;
        sif.game_over_in     = 1'b0;
        sif.menu_busy_in     = 1'b0;
        sif.menu_finished_in = 1'b0;
        sif.menu_pixel_in    = 12'h123;
        sif.game_pixel_in    = 12'h456;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 16'(sif.state_out), 16'h0);
        checkOutput("reset_pixel", 16'(sif.pixel_out), 16'h0);
        checkOutput("reset_run", 16'(sif.game_run_out), 16'h0);
        checkOutput("reset_start", 16'(sif.menu_start_out), 16'h0);
        checkOutput("reset_demo", 16'(sif.demo_out), 16'h0);
        rst = 1'b1;

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("menu_pixel", 16'(sif.pixel_out), 16'h123);
        checkOutput("no_frame", 16'(sif.frame_out), 16'h0);

        sif.hcount_in = 11'd1279;
        sif.vcount_in = 10'd718;
        @(posedge clk);
        #1;
        checkOutput("frame_row718", 16'(sif.frame_out), 16'h0);

        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("first_frame", 16'(sif.frame_out), 16'h1);
        checkOutput("first_start", 16'(sif.menu_start_out), 16'h1);
        checkOutput("menu_state", 16'(sif.state_out), 16'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("start_oneshot", 16'(sif.menu_start_out), 16'h0);
        checkOutput("frame_oneshot", 16'(sif.frame_out), 16'h0);

        applyStimulus(0, 1, 0, 0, 0);
        sif.menu_busy_in = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sel_not_ready", 16'(sif.state_out), 16'h0);
        checkOutput("busy_no_start", 16'(sif.menu_start_out), 16'h0);
        sif.menu_busy_in = 1'b0;

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("sel_dropped", 16'(sif.state_out), 16'h0);
        checkOutput("ready_no_start", 16'(sif.menu_start_out), 16'h0);

        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sel_on_tick_held", 16'(sif.state_out), 16'h0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("enter_play", 16'(sif.state_out), 16'h1);
        checkOutput("play_run", 16'(sif.game_run_out), 16'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("play_pixel", 16'(sif.pixel_out), 16'h456);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("play_sel_ignored", 16'(sif.state_out), 16'h1);

        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("enter_pause", 16'(sif.state_out), 16'h2);
        checkOutput("pause_run", 16'(sif.game_run_out), 16'h0);
        sif.menu_pixel_in = 12'h000;
        sif.game_pixel_in = 12'hF84;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pause_dim", 16'(sif.pixel_out), 16'h742);
        sif.menu_pixel_in = 12'h0F0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pause_overlay", 16'(sif.pixel_out), 16'h0F0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("pause_start", 16'(sif.menu_start_out), 16'h1);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resume_play", 16'(sif.state_out), 16'h1);

        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("no_early_change", 16'(sif.state_out), 16'h1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("over_beats_back", 16'(sif.state_out), 16'h3);
        checkOutput("over_run", 16'(sif.game_run_out), 16'h0);
        sif.menu_pixel_in = 12'hABC;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("over_pixel", 16'(sif.pixel_out), 16'hABC);

        for (int i = 0; i < 179; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("over_hold_179", 16'(sif.state_out), 16'h3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("over_to_menu", 16'(sif.state_out), 16'h0);

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("replay", 16'(sif.state_out), 16'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("replay_pixel", 16'(sif.pixel_out), 16'hF84);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_state", 16'(sif.state_out), 16'h0);
        checkOutput("async_run", 16'(sif.game_run_out), 16'h0);
        checkOutput("async_pixel", 16'(sif.pixel_out), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_reset_nostart", 16'(sif.menu_start_out), 16'h0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post_reset_start", 16'(sif.menu_start_out), 16'h1);

`ifdef ATTRACT_MODE_EN
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 599; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("idle_599", 16'(sif.state_out), 16'h0);
        checkOutput("idle_599_demo", 16'(sif.demo_out), 16'h0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("attract_state", 16'(sif.state_out), 16'h1);
        checkOutput("attract_demo", 16'(sif.demo_out), 16'h1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("demo_over_menu", 16'(sif.state_out), 16'h0);
        checkOutput("demo_cleared", 16'(sif.demo_out), 16'h0);
`else
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, i == 0);
        checkOutput("no_attract_demo", 16'(sif.demo_out), 16'h0);
        checkOutput("no_attract_state", 16'(sif.state_out), 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
Top-level screen controller for the game display. It runs the MENU/PLAY/PAUSE/OVER phase state machine and drives state_in of the menu renderer. It starts and monitors the renderer through its busy/finished handshake, and gates the game logic. It also owns the final registered pixel mux between the menu renderer and the game renderer. All phase changes take effect only at the frame boundary, so no frame tears.

Parameters:
H_LAST, 1279, last active hcount (720p)
V_LAST, 719, last active vcount
OVER_FRAMES, 180, frames the game-over screen holds before returning to MENU (3 s at 60 Hz)
IDLE_FRAMES, 600, idle MENU frames before attract demo (used only with ATTRACT_MODE_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current pixel row
btn_select_in  in  1  debounced one-cycle select pulse
btn_back_in  in  1  debounced one-cycle back pulse
game_over_in  in  1  one-cycle pulse from game logic
menu_busy_in  in  1  menu renderer busy
menu_finished_in  in  1  menu renderer one-cycle done pulse
menu_pixel_in  in  12  menu renderer RGB444
game_pixel_in  in  12  game renderer RGB444
state_out  out  2  phase code, feeds menu state_in
menu_start_out  out  1  one-cycle start pulse to menu renderer
game_run_out  out  1  game logic enable
demo_out  out  1  attract-demo flag
frame_out  out  1  one-cycle pulse at frame boundary
pixel_out  out  12  registered RGB444 to video output

Behaviour:
- Reset (rst=0, async): phase=MENU, state_out=2'b00, all pulses 0, game_run_out=0, demo_out=0, pixel_out=0, pending command cleared, menu_ready=0, frame counter=0.
- Phase encoding: MENU=00, PLAY=01, PAUSE=10, OVER=11. state_out is a registered copy of the phase.
- frame_tick is combinational: (hcount_in==H_LAST && vcount_in==V_LAST). frame_out is frame_tick registered, so it has 1-cycle latency.
- Command latch: a button or game_over pulse sets the 2-bit pending command (NONE/SELECT/BACK/OVER).
  - Priority when pulses coincide, or when a pulse arrives while a command is already pending: OVER > BACK > SELECT.
  - The pending command is consumed and cleared on frame_tick.
  - A pulse arriving in the same cycle as frame_tick is held for the next frame.
- menu_ready: set by menu_finished_in, cleared on any phase change.
- Menu start: in MENU, PAUSE or OVER, on frame_tick with menu_busy_in=0 and menu_ready=0, assert menu_start_out for exactly one cycle.
  - With menu_busy_in=1 there is no start; retry at the next frame_tick.
- Transitions, evaluated only on frame_tick:
  - MENU: SELECT with menu_ready=1 goes to PLAY. SELECT with menu_ready=0 is dropped.
  - PLAY: OVER goes to OVER. BACK goes to PAUSE. SELECT is ignored.
  - PAUSE: SELECT goes to PLAY. BACK goes to MENU. OVER goes to OVER.
  - OVER: SELECT goes to MENU. Otherwise the frame counter increments per frame_tick; when it reaches OVER_FRAMES-1, go to MENU.
  - The frame counter clears on every phase change. It is 10 bits wide and saturates, never wraps.
- game_run_out=1 only in PLAY. It drops in the same cycle the phase register leaves PLAY.
- Pixel mux, registered, 1-cycle latency from pixel inputs to pixel_out:
  - MENU and OVER: menu_pixel_in.
  - PLAY: game_pixel_in.
  - PAUSE: if menu_pixel_in is non-zero, pass menu_pixel_in (overlay). Otherwise pass game_pixel_in dimmed, with each 4-bit channel shifted right by 1.
  - The mux selection uses the phase value of the same cycle.
- Reset mid-frame: all state returns to reset values immediately. The menu renderer is restarted at the first frame_tick after reset release.

Optional Feature:
ATTRACT_MODE_EN
- Defined:
  - In MENU with menu_ready=1, an idle counter counts frame_ticks that have no pending command. At IDLE_FRAMES it enters PLAY with demo_out=1.
  - Any button pulse while demo_out=1 gives MENU at the next frame_tick, with demo_out cleared.
  - game_over_in in demo gives MENU, not OVER.
- Undefined: no idle counter; demo_out is tied to 0.

Decomposition:
- screen_pkg holds:
  - phase_t enum (MENU, PLAY, PAUSE, OVER)
  - cmd_t enum (NONE, SELECT, BACK, OVER)
  - RGB width constant (12)
  - dim function
- One sub-module, screen_pixel_stage: the registered pixel mux plus dim, with inputs phase, menu_pixel, game_pixel.

Test Plan:
- Reset, then run frames: state_out=00, menu_start_out pulses at the first frame_tick (hcount=1279, vcount=719) with busy=0. finished -> menu_ready=1. SELECT -> state_out=01 at the next frame_tick, game_run_out=1.
- PLAY, with BACK and game_over_in in the same cycle: next frame_tick gives state_out=11, with no PAUSE visible. After 180 frames, state_out=00.
- PAUSE, menu_pixel_in=0, game_pixel_in=12'hF84: pixel_out=12'h742 one cycle later. With menu_pixel_in=12'h0F0: pixel_out=12'h0F0.
- MENU with menu_ready=0, SELECT pulse: no transition, and the command is dropped at frame_tick. menu_busy_in=1 at frame_tick: no menu_start_out.
- SELECT pulse coincident with frame_tick in MENU (ready): phase unchanged that tick, PLAY at the following tick.
- rst pulled low mid-frame in PLAY: pixel_out=0, game_run_out=0, state_out=00 asynchronously. With ATTRACT_MODE_EN, 600 idle frames give demo_out=1 and state_out=01.
